// File: rtl/clarvi_sliced_alu_pkg.sv
// Shared types for the bit-sliced RISC-V ALU: operation codes, sequencer
// states and a helper that tells which operations have a 32-bit W variant.
package clarvi_sliced_alu_pkg;

   localparam int WORD_W       = 32;
   localparam int WORD_SHIFT_W = 5;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLT  = 4'd5,
      OP_SLTU = 4'd6,
      OP_SL   = 4'd7,
      OP_SRL  = 4'd8,
      OP_SRA  = 4'd9
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

   // Only add/sub and the shifts have a W form; everything else ignores in_word.
   function automatic logic is_word_op(input alu_op_t op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SL) ||
             (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/clarvi_sliced_alu_if.sv
// Request/response bundle between a requester and the sliced ALU.
interface clarvi_sliced_alu_if
   import clarvi_sliced_alu_pkg::*;
#(
   parameter int XLEN = 64
);

   logic            in_valid;
   logic            in_ready;
   alu_op_t         in_op;
   logic            in_word;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic            busy;

   modport master (
      output in_valid, in_op, in_word, in_rs1, in_rs2, out_ready,
      input  in_ready, out_valid, out_result, busy
   );

   modport slave (
      input  in_valid, in_op, in_word, in_rs1, in_rs2, out_ready,
      output in_ready, out_valid, out_result, busy
   );

endinterface

// File: rtl/clarvi_alu_slice.sv
// One SLICE_W-wide combinational ALU slice: add/sub with carry, slice
// compare, bitwise logic and a funnel-shift select from a two-slice window.
module clarvi_alu_slice
   import clarvi_sliced_alu_pkg::*;
#(
   parameter int SLICE_W = 16
) (
   input  alu_op_t                      op,
   input  logic [SLICE_W-1:0]           a,
   input  logic [SLICE_W-1:0]           b,
   input  logic                         carry_in,
   input  logic                         cmp_signed,
   input  logic [SLICE_W-1:0]           win_lo,
   input  logic [SLICE_W-1:0]           win_hi,
   input  logic [$clog2(SLICE_W)-1:0]   shift_amt,
   output logic [SLICE_W-1:0]           y,
   output logic                         carry_out,
   output logic                         lt,
   output logic                         eq
);

   logic [SLICE_W-1:0]   b_eff;
   logic [SLICE_W:0]     sum;
   logic [2*SLICE_W-1:0] win;

   // Compute every candidate slice result and pick the one for this op.
   always_comb begin
      y         = '0;
      b_eff     = (op == OP_SUB) ? ~b : b;
      sum       = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, carry_in};
      carry_out = sum[SLICE_W];
      win       = {win_hi, win_lo};
      eq        = (a == b);
      lt        = cmp_signed ? ($signed(a) < $signed(b)) : (a < b);
      case (op)
         OP_ADD, OP_SUB: y = sum[SLICE_W-1:0];
         OP_AND:         y = a & b;
         OP_OR:          y = a | b;
         OP_XOR:         y = a ^ b;
         OP_SL:          y = SLICE_W'((win << shift_amt) >> SLICE_W);
         OP_SRL, OP_SRA: y = SLICE_W'(win >> shift_amt);
         default:        y = '0;
      endcase
   end

endmodule

// File: rtl/clarvi_sliced_alu.sv
// Multi-cycle RISC-V ALU that produces one SLICE_W result slice per cycle.
// Operands are captured on acceptance; the sequencer walks the slices
// (LSB first, or MSB first for compares) and presents the whole result in DONE.
module clarvi_sliced_alu
   import clarvi_sliced_alu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int SLICE_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   clarvi_sliced_alu_if.slave bus
);

   localparam int N       = XLEN / SLICE_W;
   localparam int HALF_N  = N / 2;
   localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
   localparam int SHIFT_W = $clog2(XLEN);
   localparam int AMT_W   = $clog2(SLICE_W);

   typedef logic [N-1:0][SLICE_W-1:0] sliced_t;

   alu_state_t        state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   alu_op_t           op_q, op_d;
   logic              word_q, word_d;
   sliced_t           rs1_q, rs1_d;
   sliced_t           rs2_q, rs2_d;
   sliced_t           result_q, result_d;
   logic              carry_q, carry_d;
   logic              decided_q, decided_d;
   logic              less_q, less_d;

   logic              in_ready;
   logic              accept;
   logic              word_mode;
   logic              is_cmp;
   logic              ext_cycle;
   logic [IDX_W-1:0]  last_cnt;
   logic [IDX_W-1:0]  idx;
   logic [SHIFT_W-1:0] shamt;
   logic [AMT_W-1:0]  shift_r;
   int                shift_slices;
   int                src_cnt;
   logic              fill;
   logic [SLICE_W-1:0] win_lo, win_hi;
   logic [SLICE_W-1:0] a_slice, b_slice;
   logic              cmp_signed;
   logic [SLICE_W-1:0] slice_y;
   logic              slice_cout;
   logic              slice_lt;
   logic              slice_eq;
   logic              less_final;

   // Source slice j of the shift input: zero below, fill above the source.
   function automatic logic [SLICE_W-1:0] src_slice(input sliced_t src, input int j,
                                                     input int cnt, input logic fill_bit);
      if (j < 0) return '0;
      if (j >= cnt) return {SLICE_W{fill_bit}};
      return src[IDX_W'(j)];
   endfunction

   assign in_ready       = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
   assign accept         = bus.in_valid && in_ready;
   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = (state_q == ST_DONE);
   assign bus.busy       = (state_q == ST_RUN);
   assign bus.out_result = result_q;

   // Select the slice being worked on this cycle and its operand/shift windows.
   always_comb begin
      word_mode    = word_q && is_word_op(op_q);
      is_cmp       = (op_q == OP_SLT) || (op_q == OP_SLTU);
      ext_cycle    = word_mode && (cnt_q == IDX_W'(HALF_N));
      last_cnt     = word_mode ? IDX_W'(HALF_N) : IDX_W'(N - 1);
      idx          = is_cmp ? (IDX_W'(N - 1) - cnt_q) : cnt_q;
      shamt        = word_mode ? SHIFT_W'(WORD_SHIFT_W'(rs2_q)) : SHIFT_W'(rs2_q);
      shift_r      = shamt[AMT_W-1:0];
      shift_slices = int'(shamt[SHIFT_W-1:AMT_W]);
      src_cnt      = word_mode ? HALF_N : N;
      fill         = (op_q == OP_SRA) &&
                     (word_mode ? rs1_q[HALF_N-1][SLICE_W-1] : rs1_q[N-1][SLICE_W-1]);
      if (op_q == OP_SL) begin
         win_hi = src_slice(rs1_q, int'(idx) - shift_slices, src_cnt, fill);
         win_lo = src_slice(rs1_q, int'(idx) - shift_slices - 1, src_cnt, fill);
      end else begin
         win_lo = src_slice(rs1_q, int'(idx) + shift_slices, src_cnt, fill);
         win_hi = src_slice(rs1_q, int'(idx) + shift_slices + 1, src_cnt, fill);
      end
      a_slice    = rs1_q[idx];
      b_slice    = rs2_q[idx];
      cmp_signed = (op_q == OP_SLT) && (idx == IDX_W'(N - 1));
      less_final = decided_q ? less_q : slice_lt;
   end

   clarvi_alu_slice #(
      .SLICE_W (SLICE_W)
   ) u_slice (
      .op         (op_q),
      .a          (a_slice),
      .b          (b_slice),
      .carry_in   (carry_q),
      .cmp_signed (cmp_signed),
      .win_lo     (win_lo),
      .win_hi     (win_hi),
      .shift_amt  (shift_r),
      .y          (slice_y),
      .carry_out  (slice_cout),
      .lt         (slice_lt),
      .eq         (slice_eq)
   );

   // Sequencer: accept, commit one slice per RUN cycle, hold the result in DONE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      word_d    = word_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      result_d  = result_q;
      carry_d   = carry_q;
      decided_d = decided_q;
      less_d    = less_q;
      case (state_q)
         ST_IDLE: begin
         end
         ST_RUN: begin
            if (ext_cycle) begin
               result_d[N-1:HALF_N] = {(XLEN/2){result_q[HALF_N-1][SLICE_W-1]}};
            end else if (is_cmp) begin
               if (!decided_q && !slice_eq) begin
                  decided_d = 1'b1;
                  less_d    = slice_lt;
               end
               result_d[idx] = (idx == '0) ? {{(SLICE_W-1){1'b0}}, less_final} : '0;
            end else begin
               result_d[idx] = slice_y;
               carry_d       = slice_cout;
            end
            if (cnt_q == last_cnt) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         state_d   = ST_RUN;
         cnt_d     = '0;
         op_d      = bus.in_op;
         word_d    = bus.in_word;
         rs1_d     = bus.in_rs1;
         rs2_d     = bus.in_rs2;
         carry_d   = (bus.in_op == OP_SUB);
         decided_d = 1'b0;
         less_d    = 1'b0;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= OP_ADD;
         word_q    <= 1'b0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         decided_q <= 1'b0;
         less_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         word_q    <= word_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         result_q  <= result_d;
         carry_q   <= carry_d;
         decided_q <= decided_d;
         less_q    <= less_d;
      end
   end

endmodule

// File: doc/clarvi_sliced_alu.md
CLARVI_SLICED_ALU -- requirements
Module: clarvi_sliced_alu

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning full operand/result width.
REQ-002 SHALL have parameter SLICE_W, default 16, meaning datapath bits processed per cycle; XLEN%SLICE_W==0 and (XLEN/2)%SLICE_W==0.
REQ-003 SHALL have port clock, input, 1 bit, sole clock; all flops rise-edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, request present.
REQ-006 SHALL have port in_ready, output, 1 bit, block accepts request this cycle.
REQ-007 SHALL have port in_op, input, alu_op_t, one of ADD SUB AND OR XOR SLT SLTU SL SRL SRA.
REQ-008 SHALL have port in_word, input, 1 bit, 32-bit (W) variant; honoured only for ADD SUB SL SRL SRA, ignored otherwise.
REQ-009 SHALL have port in_rs1, input, XLEN, first operand.
REQ-010 SHALL have port in_rs2, input, XLEN, second operand or immediate; shift amount from its low log2(XLEN) bits (5 bits when in_word).
REQ-011 SHALL have port out_valid, output, 1 bit, out_result valid.
REQ-012 SHALL have port out_ready, input, 1 bit, consumer takes result.
REQ-013 SHALL have port out_result, output, XLEN, result.
REQ-014 SHALL have port busy, output, 1 bit, high in RUN.

Function
REQ-015 SHALL implement FSM IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after last slice; DONE -> IDLE on out_ready, or DONE -> RUN if in_valid accepted same cycle.
REQ-016 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready); out_valid = (state==DONE).
REQ-017 SHALL register in_op, in_word, in_rs1, in_rs2 on acceptance; later input changes SHALL not affect the operation.
REQ-018 SHALL commit exactly one SLICE_W result slice per RUN cycle, N=XLEN/SLICE_W slices full width, N/2 slices plus one sign-extension cycle in word mode.
REQ-019 SHALL assert out_valid exactly N cycles after acceptance (N/2+1 in word mode), independent of operand values.
REQ-020 SHALL process ADD/SUB LSB slice first, carrying one carry bit between slices; SUB = rs1 + ~rs2 + 1 with initial carry 1.
REQ-021 SHALL process SLT/SLTU MSB slice first, tracking (decided, less) flags; top slice signed for SLT, all other slices unsigned; result = {XLEN-1 zeros, less}; equal operands give 0.
REQ-022 SHALL compute each shift slice i from source bits [i*SLICE_W+k ...] across two adjacent source slices, filling with 0 (SL, SRL) or sign (SRA); shift 0 returns rs1 unchanged.
REQ-023 SHALL, in word mode, use rs1[31:0] as source, fill right shifts from bit 31 (SRA) or 0 (SRL), then set result[XLEN-1:32] to result bit 31 in the extension cycle.
REQ-024 SHALL hold out_result and out_valid stable while out_valid && !out_ready.
REQ-025 SHALL compute AND/OR/XOR per slice with no inter-slice state.

Reset
REQ-026 SHALL on reset low immediately force state IDLE, out_valid 0, busy 0, out_result 0, carry/compare flags 0; in_ready reads 1 once in IDLE.
REQ-027 SHALL abandon any in-flight operation on reset with no partial result ever presented.

Structure
REQ-028 SHALL take alu_op_t and the FSM state enum from the shared riscv package header; no local redefinition.
REQ-029 SHALL place one-slice combinational datapath (add/sub, compare, logic, shift-select) in sub-module clarvi_alu_slice, parametrised by SLICE_W; sequencing, operand and result registers stay in clarvi_sliced_alu.

Verification (XLEN=64, SLICE_W=16)
REQ-030 SHALL test ADD rs1=0x0000_0000_0000_FFFF, rs2=1 -> 0x0000_0000_0001_0000, out_valid 4 cycles after accept.
REQ-031 SHALL test SUB word rs1=0, rs2=1 -> 0xFFFF_FFFF_FFFF_FFFF, out_valid 3 cycles after accept.
REQ-032 SHALL test SLT rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=0 -> 1; SLTU same operands -> 0; SLT equal operands -> 0.
REQ-033 SHALL test SRA rs1=0x8000_0000_0000_0000, shift 20 -> 0xFFFF_F800_0000_0000; SRL word rs1=0xFFFF_FFFF_8000_0000, shift 4 -> 0x0000_0000_0800_0000.
REQ-034 SHALL test out_ready low 3 cycles in DONE -> out_result stable, in_ready 0; then out_ready=1 with in_valid=1 same cycle -> new op accepted, back-to-back results correct.
REQ-035 SHALL test reset low during second RUN cycle -> out_valid 0 immediately, in_ready 1 after release, following ADD 2+3 -> 5.
